// File: rtl/axis_pattern_burst_ctrl.sv
// AXI-Stream pattern generator: bursts of incrementing data separated by idle gaps.
// One start runs cfg_num_bursts bursts (0 = run until abort); abort ends cleanly on a beat.
module axis_pattern_burst_ctrl #(
    parameter int M00_AXIS_TDATA_WIDTH = 32,
    parameter int COUNTER_START        = 1,
    parameter int COUNTER_INCR         = 1,
    parameter int CFG_WIDTH            = 16
) (
    input  logic                            m_axis_aclk,
    input  logic                            m_axis_areset,
    input  logic                            start,
    input  logic                            abort,
    input  logic [CFG_WIDTH-1:0]            cfg_burst_len,
    input  logic [CFG_WIDTH-1:0]            cfg_num_bursts,
    input  logic [CFG_WIDTH-1:0]            cfg_gap,
    input  logic                            m_axis_tready,
    output logic [M00_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    output logic                            busy,
    output logic                            done,
    output logic [CFG_WIDTH-1:0]            burst_cnt
);

    // state | meaning
    // IDLE  | waiting for start, tvalid low
    // SEND  | presenting beats of the current burst
    // GAP   | tvalid low, counting idle cycles before the next burst
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [M00_AXIS_TDATA_WIDTH-1:0] START_V = M00_AXIS_TDATA_WIDTH'(COUNTER_START);
    localparam logic [M00_AXIS_TDATA_WIDTH-1:0] INCR_V  = M00_AXIS_TDATA_WIDTH'(COUNTER_INCR);
    localparam logic [CFG_WIDTH-1:0]            CFG_ONE = CFG_WIDTH'(1);
    localparam logic [CFG_WIDTH-1:0]            CFG_TWO = CFG_WIDTH'(2);

    state_t                            state_q, state_d;
    logic [M00_AXIS_TDATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                              tvalid_q, tvalid_d;
    logic                              tlast_q, tlast_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic                              abort_q, abort_d;
    logic [CFG_WIDTH-1:0]              burst_cnt_q, burst_cnt_d;
    logic [CFG_WIDTH-1:0]              len_q, len_d;
    logic [CFG_WIDTH-1:0]              num_q, num_d;
    logic [CFG_WIDTH-1:0]              gap_q, gap_d;
    logic [CFG_WIDTH-1:0]              beat_rem_q, beat_rem_d;
    logic [CFG_WIDTH-1:0]              gap_rem_q, gap_rem_d;

    logic                 accept;
    logic                 abort_now;
    logic [CFG_WIDTH-1:0] len_eff;

    assign accept    = tvalid_q & m_axis_tready;
    assign abort_now = abort_q | abort;
    assign len_eff   = (cfg_burst_len == '0) ? CFG_ONE : cfg_burst_len;

    always_comb begin
        state_d     = state_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        done_d      = 1'b0;
        abort_d     = abort_q;
        burst_cnt_d = burst_cnt_q;
        len_d       = len_q;
        num_d       = num_q;
        gap_d       = gap_q;
        beat_rem_d  = beat_rem_q;
        gap_rem_d   = gap_rem_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    len_d       = len_eff;
                    num_d       = cfg_num_bursts;
                    gap_d       = cfg_gap;
                    burst_cnt_d = '0;
                    tdata_d     = START_V;
                    tvalid_d    = 1'b1;
                    tlast_d     = (len_eff == CFG_ONE);
                    beat_rem_d  = len_eff;
                    abort_d     = 1'b0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    if (tlast_q) begin
                        burst_cnt_d = burst_cnt_q + CFG_ONE;
                    end
                    if (abort_now) begin
                        state_d  = IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        abort_d  = 1'b0;
                    end else if (tlast_q) begin
                        if ((num_q != '0) && ((burst_cnt_q + CFG_ONE) == num_q)) begin
                            state_d  = IDLE;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                            done_d   = 1'b1;
                        end else if (gap_q == '0) begin
                            tdata_d    = START_V;
                            tlast_d    = (len_q == CFG_ONE);
                            beat_rem_d = len_q;
                        end else begin
                            state_d   = GAP;
                            tvalid_d  = 1'b0;
                            tlast_d   = 1'b0;
                            gap_rem_d = gap_q;
                        end
                    end else begin
                        tdata_d    = tdata_q + INCR_V;
                        beat_rem_d = beat_rem_q - CFG_ONE;
                        tlast_d    = (beat_rem_q == CFG_TWO);
                    end
                end else if (abort) begin
                    // stalled beat becomes the closing beat of the sequence
                    abort_d = 1'b1;
                    tlast_d = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_rem_q == CFG_ONE) begin
                    state_d    = SEND;
                    tvalid_d   = 1'b1;
                    tdata_d    = START_V;
                    tlast_d    = (len_q == CFG_ONE);
                    beat_rem_d = len_q;
                end else begin
                    gap_rem_d = gap_rem_q - CFG_ONE;
                end
            end
            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            state_q     <= IDLE;
            tdata_q     <= START_V;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            burst_cnt_q <= '0;
            len_q       <= '0;
            num_q       <= '0;
            gap_q       <= '0;
            beat_rem_q  <= '0;
            gap_rem_q   <= '0;
        end else begin
            state_q     <= state_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            burst_cnt_q <= burst_cnt_d;
            len_q       <= len_d;
            num_q       <= num_d;
            gap_q       <= gap_d;
            beat_rem_q  <= beat_rem_d;
            gap_rem_q   <= gap_rem_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign burst_cnt     = burst_cnt_q;

endmodule

// File: doc/axis_pattern_burst_ctrl.md
AXIS_PATTERN_BURST_CTRL -- requirements
Module: axis_pattern_burst_ctrl

Interface
REQ-001 Parameter M00_AXIS_TDATA_WIDTH, default 32: width of m_axis_tdata.
REQ-002 Parameter COUNTER_START, default 1: first data value of every burst.
REQ-003 Parameter COUNTER_INCR, default 1: data increment per accepted beat.
REQ-004 Parameter CFG_WIDTH, default 16: width of all cfg_* inputs and burst_cnt.
REQ-005 The block has one clock and a synchronous, active-high reset.
REQ-006 m_axis_aclk  in  1  clock; all logic on the rising edge.
REQ-007 m_axis_areset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to begin a sequence; honoured only in IDLE.
REQ-009 abort  in  1  level or pulse; ends the sequence early per REQ-022.
REQ-010 cfg_burst_len  in  CFG_WIDTH  beats per burst; 0 is treated as 1.
REQ-011 cfg_num_bursts  in  CFG_WIDTH  bursts per sequence; 0 means run until abort.
REQ-012 cfg_gap  in  CFG_WIDTH  idle cycles (tvalid low) between bursts.
REQ-013 m_axis_tready  in  1  AXIS sink ready.
REQ-014 m_axis_tdata  out  M00_AXIS_TDATA_WIDTH  pattern data.
REQ-015 m_axis_tvalid  out  1  AXIS valid.
REQ-016 m_axis_tlast  out  1  high on the final beat of each burst.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle pulse on normal sequence completion.
REQ-019 burst_cnt  out  CFG_WIDTH  number of bursts completed since the last accepted start.

Function
REQ-020 The FSM shall have three states: IDLE, SEND and GAP; all outputs shall be registered.
REQ-021 In IDLE, start latches cfg_*, clears burst_cnt and loads tdata with COUNTER_START; tvalid rises on the next cycle (1-cycle latency) and the state becomes SEND.
REQ-022 abort handling:
- in SEND, abort completes the beat currently presented; that beat is forced tlast=1 and held until accepted, then the FSM goes to IDLE;
- in GAP, abort goes to IDLE on the next cycle;
- done shall not pulse on any abort.
REQ-023 A beat is accepted when tvalid and tready are both high; tvalid, tdata and tlast shall stay stable while tvalid=1 and tready=0.
REQ-024 In SEND, each non-final accepted beat presents the next beat on the next cycle with no bubble; tdata = previous + COUNTER_INCR, wrapping modulo 2^M00_AXIS_TDATA_WIDTH.
REQ-025 tlast shall be high on beat number max(cfg_burst_len,1) of each burst only (or on the abort beat per REQ-022).
REQ-026 On acceptance of a tlast beat, burst_cnt increments by 1, wrapping modulo 2^CFG_WIDTH.
REQ-027 Last-beat transitions:
- if this was the final burst (burst_cnt+1 == cfg_num_bursts, cfg_num_bursts != 0): go to IDLE and pulse done in the same cycle tvalid falls;
- else if cfg_gap = 0: the next burst's first beat (tdata = COUNTER_START) is presented on the next cycle;
- else: go to GAP with tvalid low for exactly cfg_gap cycles, then return to SEND with tdata = COUNTER_START.
REQ-028 start received while busy=1 shall be ignored; cfg_* changes while busy shall have no effect.
REQ-029 start and abort high together in IDLE: start shall be ignored and the FSM shall stay in IDLE.
REQ-030 tready may be high while tvalid is low; this shall not alter any state.

Reset
REQ-031 While m_axis_areset=1:
- the FSM is in IDLE;
- tvalid, tlast, busy and done are 0;
- burst_cnt is 0;
- tdata is COUNTER_START truncated to width.
REQ-032 Reset asserted mid-burst shall drop tvalid on the next edge without completing the beat and shall discard all latched configuration.

Verification
REQ-033 len=4, bursts=2, gap=3, tready=1 -> tdata 1,2,3,4 (tlast on 4), 3 cycles tvalid=0, then 1,2,3,4 (tlast on 4), done pulses once, burst_cnt=2.
REQ-034 len=3, bursts=1, tready toggling 1,0,0,1,... -> tdata/tlast held during stalls, exactly 3 beats 1,2,3 accepted, done after third acceptance.
REQ-035 len=0, bursts=3, gap=0 -> three single-beat bursts tdata=1 with tlast=1 on consecutive cycles, burst_cnt=3.
REQ-036 bursts=0, len=2; abort while beat 2 is stalled with tready=0 -> beat held until tready=1, then IDLE, busy=0, done never pulses.
REQ-037 M00_AXIS_TDATA_WIDTH=4, COUNTER_START=14, COUNTER_INCR=1, len=4 -> tdata 14,15,0,1.
REQ-038 Reset asserted mid-burst, then start with len=2, bursts=1 -> fresh sequence 1,2, burst_cnt=1, done pulses once.
